// File: rtl/grayscale_upsampler_if.sv
// Streaming bus of the grayscale upsampler: input pixel handshake, output pixel handshake, frame syncs.
// Latency: none, this file only groups wires.
// Backpressure: data_in_ready throttles the source, data_out_ready throttles the upsampler.
// Ports (slave = upsampler side):
//   data_in_valid/data_in_ready/data_in/vsync_in   source -> upsampler
//   data_out_valid/data_out_ready/data_out/vsync_out upsampler -> sink
interface grayscale_upsampler_if #(
  parameter int data_width = 8
) ();
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic                  vsync_in;
  logic [data_width-1:0] data_in;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  vsync_out;
  logic [data_width-1:0] data_out;

  modport slave (
    input  data_in_valid, vsync_in, data_in, data_out_ready,
    output data_in_ready, data_out_valid, vsync_out, data_out
  );

  modport master (
    output data_in_valid, vsync_in, data_in, data_out_ready,
    input  data_in_ready, data_out_valid, vsync_out, data_out
  );
endinterface

// File: rtl/grayscale_upsampler.sv
// Pixel-replicating upscaler: every input pixel becomes a scale_x x scale_y block of output pixels.
// Latency: pixel accepted at edge N is on data_out after edge N; one bubble at the start of replayed rows.
// Backpressure: output register holds while data_out_ready is low; input is only taken on the last replica.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   bus     grayscale_upsampler_if.slave (input/output handshakes, vsync_in, vsync_out)
module grayscale_upsampler #(
  parameter int data_width   = 8,
  parameter int image_width  = 160,
  parameter int image_height = 120,
  parameter int scale_x      = 2,
  parameter int scale_y      = 2
) (
  input logic                   clock,
  input logic                   reset,
  grayscale_upsampler_if.slave  bus
);

  localparam int XW  = (image_width  > 1) ? $clog2(image_width)  : 1;
  localparam int YW  = (image_height > 1) ? $clog2(image_height) : 1;
  localparam int SXW = (scale_x      > 1) ? $clog2(scale_x)      : 1;
  localparam int SYW = (scale_y      > 1) ? $clog2(scale_y)      : 1;
  // Read pointer needs one extra value to mark "whole row already fetched".
  localparam int RW  = $clog2(image_width + 1);

  localparam logic [XW-1:0]  X_LAST  = XW'(image_width - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(image_height - 1);
  localparam logic [SXW-1:0] SX_LAST = SXW'(scale_x - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(scale_y - 1);
  localparam logic [RW-1:0]  RD_END  = RW'(image_width);

  typedef enum logic {ROW0, REPLAY} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         in_x_q, in_x_d;     // column of the pixel held (or next to load)
  logic [YW-1:0]         in_y_q, in_y_d;
  logic [SXW-1:0]        rep_x_q, rep_x_d;
  logic [SYW-1:0]        rep_y_q, rep_y_d;
  logic [RW-1:0]         rd_x_q, rd_x_d;     // next line-buffer address to fetch in REPLAY
  logic                  rd_pend_q, rd_pend_d; // rd_dat_q holds a fetched, not yet used word
  logic                  out_vld_q, out_vld_d;
  logic                  out_vs_q, out_vs_d;
  logic [data_width-1:0] out_dat_q, out_dat_d;

  logic [data_width-1:0] lb_mem [image_width];
  logic [data_width-1:0] rd_dat_q;

  logic                  wr_en, rd_en, in_rdy;
  logic [XW-1:0]         wr_addr, rd_addr;
  logic                  out_xfer, last_rep, retire, row_last, need, load, issue;

  always_comb begin
    state_d   = state_q;
    in_x_d    = in_x_q;
    in_y_d    = in_y_q;
    rep_x_d   = rep_x_q;
    rep_y_d   = rep_y_q;
    rd_x_d    = rd_x_q;
    rd_pend_d = rd_pend_q;
    out_vld_d = out_vld_q;
    out_vs_d  = out_vs_q;
    out_dat_d = out_dat_q;
    wr_en     = 1'b0;
    wr_addr   = in_x_q;
    rd_en     = 1'b0;
    rd_addr   = rd_x_q[XW-1:0];
    in_rdy    = 1'b0;
    load      = 1'b0;
    issue     = 1'b0;

    out_xfer = out_vld_q & bus.data_out_ready;
    last_rep = (rep_x_q == SX_LAST);
    retire   = out_xfer & last_rep;
    row_last = (in_x_q == X_LAST);
    need     = !out_vld_q | retire;

    if (bus.vsync_in) begin
      // Frame resync: drop everything in flight, including any prefetched word.
      state_d   = ROW0;
      in_x_d    = '0;
      in_y_d    = '0;
      rep_x_d   = '0;
      rep_y_d   = '0;
      rd_x_d    = '0;
      rd_pend_d = 1'b0;
      out_vld_d = 1'b0;
      out_vs_d  = 1'b0;
    end else begin
      if (out_xfer) begin
        out_vs_d = 1'b0;
        if (!last_rep) rep_x_d = rep_x_q + SXW'(1);
      end

      if (retire) begin
        out_vld_d = 1'b0;
        rep_x_d   = '0;
        if (row_last) begin
          in_x_d = '0;
          if (rep_y_q == SY_LAST) begin
            rep_y_d = '0;
            in_y_d  = (in_y_q == Y_LAST) ? '0 : in_y_q + YW'(1);
            state_d = ROW0;
          end else begin
            // Another copy of this row is due: start fetching address 0 right away.
            rep_y_d   = rep_y_q + SYW'(1);
            state_d   = REPLAY;
            rd_en     = 1'b1;
            rd_addr   = '0;
            rd_x_d    = RW'(1);
            rd_pend_d = 1'b1;
          end
        end else begin
          in_x_d = in_x_q + XW'(1);
        end
      end

      case (state_q)
        ROW0: begin
          // Once the last column is held and the row must be replayed, the next row waits.
          in_rdy = reset & need & !(out_vld_q & row_last & (rep_y_q != SY_LAST));
          if (in_rdy & bus.data_in_valid) begin
            wr_en     = 1'b1;
            wr_addr   = in_x_d;
            out_dat_d = bus.data_in;
            out_vld_d = 1'b1;
            rep_x_d   = '0;
            out_vs_d  = (in_x_d == '0) && (in_y_d == '0);
          end
        end
        REPLAY: begin
          load  = need & rd_pend_q;
          issue = (rd_x_q < RD_END) & (!rd_pend_q | load);
          if (load) begin
            out_dat_d = rd_dat_q;
            out_vld_d = 1'b1;
            rep_x_d   = '0;
            out_vs_d  = 1'b0;
          end
          // Refill the prefetch register in the same cycle it is consumed.
          if (issue) begin
            rd_en     = 1'b1;
            rd_addr   = rd_x_q[XW-1:0];
            rd_x_d    = rd_x_q + RW'(1);
            rd_pend_d = 1'b1;
          end else if (load) begin
            rd_pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ROW0;
      in_x_q    <= '0;
      in_y_q    <= '0;
      rep_x_q   <= '0;
      rep_y_q   <= '0;
      rd_x_q    <= '0;
      rd_pend_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_vs_q  <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      in_x_q    <= in_x_d;
      in_y_q    <= in_y_d;
      rep_x_q   <= rep_x_d;
      rep_y_q   <= rep_y_d;
      rd_x_q    <= rd_x_d;
      rd_pend_q <= rd_pend_d;
      out_vld_q <= out_vld_d;
      out_vs_q  <= out_vs_d;
      out_dat_q <= out_dat_d;
    end
  end

  // Line buffer: plain RAM, no reset; contents are always rewritten before being replayed.
  always_ff @(posedge clock) begin
    if (wr_en) lb_mem[wr_addr] <= bus.data_in;
    if (rd_en) rd_dat_q <= lb_mem[rd_addr];
  end

  assign bus.data_in_ready  = in_rdy;
  assign bus.data_out_valid = out_vld_q;
  assign bus.vsync_out      = out_vs_q;
  assign bus.data_out       = out_dat_q;

endmodule

// File: tb/tb_grayscale_upsampler.sv
// Testbench for grayscale_upsampler: four differently parameterised instances share one stimulus
// port through a selector; unselected instances are held idle by vsync_in.
// Outputs are collected per transfer and compared with a frame-level replication model.
module tb_grayscale_upsampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] sel;
  logic       in_valid, vs_in, out_ready;
  logic [7:0] din;
  logic       in_ready, out_valid, vs_out;
  logic [7:0] dout;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] in_q[$];
  logic [7:0] frame_pix[$];
  logic [7:0] got_dat[$];
  logic       got_vs[$];
  logic [7:0] exp_dat[$];
  logic       exp_vs[$];
  int first_acc, first_out, bubbles;

  grayscale_upsampler_if #(.data_width(8)) if0 ();
  grayscale_upsampler_if #(.data_width(8)) if1 ();
  grayscale_upsampler_if #(.data_width(8)) if2 ();
  grayscale_upsampler_if #(.data_width(8)) if3 ();

  grayscale_upsampler #(.data_width(8), .image_width(4), .image_height(2), .scale_x(2), .scale_y(2))
    u0 (.clock(clk), .reset(rst_n), .bus(if0.slave));
  grayscale_upsampler #(.data_width(8), .image_width(16), .image_height(8), .scale_x(3), .scale_y(2))
    u1 (.clock(clk), .reset(rst_n), .bus(if1.slave));
  grayscale_upsampler #(.data_width(8), .image_width(4), .image_height(4), .scale_x(1), .scale_y(1))
    u2 (.clock(clk), .reset(rst_n), .bus(if2.slave));
  grayscale_upsampler #(.data_width(8), .image_width(4), .image_height(2), .scale_x(2), .scale_y(3))
    u3 (.clock(clk), .reset(rst_n), .bus(if3.slave));

  assign if0.data_in_valid  = (sel == 2'd0) && in_valid;
  assign if0.vsync_in       = (sel != 2'd0) || vs_in;
  assign if0.data_in        = din;
  assign if0.data_out_ready = (sel == 2'd0) && out_ready;
  assign if1.data_in_valid  = (sel == 2'd1) && in_valid;
  assign if1.vsync_in       = (sel != 2'd1) || vs_in;
  assign if1.data_in        = din;
  assign if1.data_out_ready = (sel == 2'd1) && out_ready;
  assign if2.data_in_valid  = (sel == 2'd2) && in_valid;
  assign if2.vsync_in       = (sel != 2'd2) || vs_in;
  assign if2.data_in        = din;
  assign if2.data_out_ready = (sel == 2'd2) && out_ready;
  assign if3.data_in_valid  = (sel == 2'd3) && in_valid;
  assign if3.vsync_in       = (sel != 2'd3) || vs_in;
  assign if3.data_in        = din;
  assign if3.data_out_ready = (sel == 2'd3) && out_ready;

  always_comb begin
    in_ready = if0.data_in_ready;  out_valid = if0.data_out_valid;
    vs_out   = if0.vsync_out;      dout      = if0.data_out;
    case (sel)
      2'd1: begin in_ready = if1.data_in_ready; out_valid = if1.data_out_valid;
                  vs_out = if1.vsync_out; dout = if1.data_out; end
      2'd2: begin in_ready = if2.data_in_ready; out_valid = if2.data_out_valid;
                  vs_out = if2.vsync_out; dout = if2.data_out; end
      2'd3: begin in_ready = if3.data_in_ready; out_valid = if3.data_out_valid;
                  vs_out = if3.vsync_out; dout = if3.data_out; end
      default: ;
    endcase
  end

  task automatic check_eq(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Output pixel (ox,oy) is input pixel (ox/sx, oy/sy); vsync only on (0,0).
  task automatic model_frame(input int w, input int h, input int sx, input int sy, input int base);
    for (int oy = 0; oy < h * sy; oy++)
      for (int ox = 0; ox < w * sx; ox++) begin
        exp_dat.push_back(frame_pix[base + (oy / sy) * w + ox / sx]);
        exp_vs.push_back(oy == 0 && ox == 0);
      end
  endtask

  task automatic load_pixels(input int n, input int start, input bit rnd);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = rnd ? 8'($urandom) : 8'(start + i);
      frame_pix.push_back(p);
      in_q.push_back(p);
    end
  endtask

  task automatic clear_all();
    in_q.delete(); frame_pix.delete(); exp_dat.delete(); exp_vs.delete();
  endtask

  // Drive at negedge, sample 1 time unit later; collect n_out output transfers or give up.
  task automatic run_stream(input int n_out, input int vpct, input int rpct, input int budget);
    int   cyc = 0;
    logic stall_prev = 1'b0;
    logic [7:0] d_prev = '0;
    logic v_prev = 1'b0;
    got_dat.delete(); got_vs.delete();
    first_acc = -1; first_out = -1; bubbles = 0;
    while (got_dat.size() < n_out && cyc < budget) begin
      @(negedge clk);
      in_valid  = (in_q.size() > 0) && (int'($urandom_range(99)) < vpct);
      din       = (in_q.size() > 0) ? in_q[0] : 8'($urandom);
      out_ready = int'($urandom_range(99)) < rpct;
      #1;
      if (stall_prev)
        check_eq("stall_hold", int'({out_valid, vs_out, dout}), int'({1'b1, v_prev, d_prev}));
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
      end else if (first_out >= 0) begin
        bubbles++;
      end
      if (out_valid && out_ready) begin
        got_dat.push_back(dout);
        got_vs.push_back(vs_out);
      end
      stall_prev = out_valid && !out_ready;
      d_prev = dout;
      v_prev = vs_out;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("transfer_count", got_dat.size(), n_out);
  endtask

  task automatic compare_out(input string tag);
    check_eq({tag, "_len"}, got_dat.size(), exp_dat.size());
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++)
      check_eq($sformatf("%s_px%0d", tag, i), int'({got_vs[i], got_dat[i]}), int'({exp_vs[i], exp_dat[i]}));
  endtask

  task automatic check_idle(input string tag);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_eq(tag, int'(out_valid), 0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_dat;
    logic       exp_vs;
  } vec_t;

  initial begin
    vec_t       tbl[32];
    logic [7:0] r01[8];
    logic [7:0] r23[8];

    r01 = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13};
    r23 = '{8'h14, 8'h14, 8'h15, 8'h15, 8'h16, 8'h16, 8'h17, 8'h17};
    for (int i = 0; i < 32; i++) begin
      tbl[i].din     = 8'h10 + 8'(i % 8);
      tbl[i].exp_dat = (i < 16) ? r01[i % 8] : r23[i % 8];
      tbl[i].exp_vs  = (i == 0);
    end

    sel = 2'd0; rst_n = 1'b0; in_valid = 1'b0; vs_in = 1'b0; out_ready = 1'b0; din = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_data_out", int'(dout), 0);
    check_eq("rst_vsync_out", int'(vs_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("post_rst_in_ready", int'(in_ready), 1);

    // Frame expansion 4x2, scale 2x2, table driven
    clear_all();
    for (int i = 0; i < 8; i++) in_q.push_back(tbl[i].din);
    run_stream(32, 100, 100, 300);
    for (int i = 0; i < 32 && i < got_dat.size(); i++)
      check_eq($sformatf("expand_px%0d", i), int'({got_vs[i], got_dat[i]}),
               int'({tbl[i].exp_vs, tbl[i].exp_dat}));
    check_eq("expand_bubbles_le3", int'(bubbles <= 3), 1);
    check_idle("expand_idle_after");

    // Random backpressure 16x8, scale 3x2
    sel = 2'd1;
    clear_all();
    load_pixels(128, 0, 1'b1);
    model_frame(16, 8, 3, 2, 0);
    run_stream(768, 70, 60, 20000);
    compare_out("rand");
    check_idle("rand_idle_after");

    // Passthrough 4x4, scale 1x1
    sel = 2'd2;
    clear_all();
    load_pixels(16, 0, 1'b1);
    model_frame(4, 4, 1, 1, 0);
    run_stream(16, 100, 100, 200);
    compare_out("pass");
    check_eq("pass_latency", first_out - first_acc, 1);
    check_eq("pass_bubbles", bubbles, 0);

    // vsync_in pulse during the replay of input row 1
    sel = 2'd0;
    clear_all();
    load_pixels(8, 8'h20, 1'b0);
    run_stream(27, 100, 100, 300);
    vs_in = 1'b1; out_ready = 1'b1;
    #1 check_eq("vsync_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    vs_in = 1'b0;
    #1 check_eq("vsync_valid_drop", int'(out_valid), 0);
    clear_all();
    load_pixels(8, 8'h80, 1'b0);
    model_frame(4, 2, 2, 2, 0);
    run_stream(32, 100, 100, 300);
    compare_out("after_vsync");

    // Asynchronous reset between edges, mid-row
    clear_all();
    load_pixels(8, 8'h40, 1'b0);
    run_stream(5, 100, 100, 100);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", int'(out_valid), 0);
    check_eq("arst_data_out", int'(dout), 0);
    check_eq("arst_vsync_out", int'(vs_out), 0);
    check_eq("arst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("arst_release_in_ready", int'(in_ready), 1);
    clear_all();
    load_pixels(8, 8'h60, 1'b0);
    model_frame(4, 2, 2, 2, 0);
    run_stream(32, 100, 80, 400);
    compare_out("after_arst");

    // Back-to-back frames 4x2, scale 2x3
    sel = 2'd3;
    clear_all();
    load_pixels(16, 0, 1'b1);
    model_frame(4, 2, 2, 3, 0);
    model_frame(4, 2, 2, 3, 8);
    run_stream(96, 100, 100, 400);
    compare_out("b2b");
    check_eq("b2b_bubbles_le11", int'(bubbles <= 11), 1);
    check_idle("b2b_idle_after");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/grayscale_upsampler.md
# grayscale_upsampler

Pixel-replicating upscaler for raster grayscale streams: each input pixel becomes a `scale_x` × `scale_y` block of identical output pixels. It is the inverse counterpart of the binning downsampler. It takes a reduced-resolution stream, such as a downsampled or processed frame, and expands it back to display or sensor resolution. One input row is held in an internal line buffer and replayed for the extra output rows. A valid/ready handshake on both sides absorbs the rate mismatch.

## Interface
- `data_width`, 8, pixel bit width
- `image_width`, 160, input pixels per row
- `image_height`, 120, input rows per frame
- `scale_x`, 2, horizontal replication factor (≥1, any integer)
- `scale_y`, 2, vertical replication factor (≥1, any integer)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `data_in_valid`  in  1  input pixel present
- `data_in_ready`  out  1  block accepts input this cycle
- `vsync_in`  in  1  frame sync, level; high = start-of-frame hold
- `data_in`  in  `data_width`  input pixel
- `data_out_valid`  out  1  output pixel present
- `data_out_ready`  in  1  downstream accepts output
- `vsync_out`  out  1  high together with the first output pixel of each frame
- `data_out`  out  `data_width`  output pixel

## Operation
- Transfers:
  - An input transfer is `data_in_valid & data_in_ready`.
  - An output transfer is `data_out_valid & data_out_ready`.
  - `data_out` and `vsync_out` are registered and stay stable while valid and not ready.
- Line buffer:
  - `image_width` words of `data_width`.
  - Synchronous write, synchronous read with 1-cycle latency.
  - Counters: `in_x` [0, image_width), `in_y` [0, image_height), `rep_x` [0, scale_x), `rep_y` [0, scale_y).
- FSM state ROW0 (output row `rep_y`=0 of each input row):
  - `data_in_ready` = `!data_out_valid | (data_out_ready & rep_x==scale_x-1)`.
  - An accepted pixel is loaded into the output register and written to the line buffer at `in_x`.
  - That pixel is emitted `scale_x` times.
  - After the last replica of `in_x`=image_width-1: if scale_y==1, advance `in_y` and stay in ROW0; otherwise go to REPLAY with `rep_y`=1.
- FSM state REPLAY:
  - `data_in_ready`=0.
  - Read the line buffer sequentially from address 0 and emit each word `scale_x` times.
  - Reads are prefetched so that no bubbles occur inside a row.
  - At row end: if `rep_y`==scale_y-1, set `rep_y`=0, advance `in_y` and return to ROW0; else increment `rep_y` and replay again.
- Frame wrap: after the final replica of `in_y`=image_height-1, all counters return to 0 and the block is ready for the next frame in ROW0.
- `vsync_out`: 1 exactly while the output register holds output pixel (0,0) of a frame; 0 otherwise.
- `vsync_in` high (synchronous):
  - Counters are cleared, state goes to ROW0, `data_out_valid` is cleared and `data_in_ready` is forced to 0.
  - Input offered during this time is dropped.
  - A partial frame in flight is discarded.
- Counter widths are `$clog2` of each range, with a minimum of 1 bit. There is no arithmetic on pixel values.

## Timing
- Reset (asynchronous, active-low) forces:
  - `data_out_valid`=0, `data_out`=0, `vsync_out`=0.
  - State ROW0, all counters 0.
  - `data_in_ready`=0 while reset is asserted, and 1 in the first cycle after deassertion (vsync_in low).
- Reset asserted mid-frame takes effect immediately. The output does not complete the current pixel.
- Latency: input accepted at edge N → `data_out_valid`=1 with that pixel after edge N.
- Throughput with `data_out_ready` held high:
  - One output pixel per cycle within a row.
  - At most one bubble cycle (valid low) at the start of each REPLAY row.
  - ROW0 sustains one output per cycle as long as the source keeps up.
- Simultaneous events:
  - Accepting the next input in the same cycle as the last replica's output transfer is required; there is no bubble.
  - `vsync_in` high overrides any transfer that cycle.
- Output backpressure never drops or duplicates pixels. Total output per frame is exactly (image_width·scale_x)·(image_height·scale_y) transfers.

## Test plan
- Frame expansion: image 4×2, scale 2×2, inputs 0x10..0x17, ready always high. Expect 8×4 output:
  - Rows 0–1 = 10,10,11,11,12,12,13,13.
  - Rows 2–3 = 14,14,…,17,17.
  - `vsync_out` only on the first pixel.
  - 32 transfers.
- Random backpressure: random `data_out_ready` and `data_in_valid`, 16×8 image, scale 3×2. Output sequence matches the reference model, with no loss or duplication and `data_out` stable while stalled.
- Passthrough: scale 1×1, 4×4 image. Output equals input in order, latency 1, REPLAY never entered, full rate.
- vsync mid-frame: pulse `vsync_in` during the REPLAY of row 1. Expect:
  - `data_out_valid` drops the next cycle.
  - Next frame restarts at (0,0) with `vsync_out`=1.
  - Stale line-buffer content is never emitted.
- Async reset mid-row: assert `reset` low between clock edges. Outputs are 0 immediately; after release, `data_in_ready`=1 and a new frame is processed correctly.
- Back-to-back frames: two 4×2 frames, scale 2×3. Expect 48 transfers per frame, `vsync_out` once per frame, and no bubble at the frame boundary beyond one per REPLAY row start.
